uio_byte_tx: RTL

// - Outbound byte port: drives bytes onto the bidirectional uio pins under a 4-phase strobe/ack handshake.
// - Complements the inbound path that reads uio_in: releases the bus (uio_oe=0) when idle, drives it (0xFF) only while sending.
// - Internal source (e.g. adder result) pushes bytes via valid/ready into a small FIFO.
// - Top level maps data_o/oe_o -> uio_out/uio_oe, stb_o -> uo_out[7], ack_i <- ui_in[7].

---
 rtl/uio_tx_pkg.sv | 14 +
 rtl/uio_byte_tx_if.sv | 12 +
 rtl/uio_byte_fifo.sv | 37 +++
 rtl/uio_byte_tx.sv | 96 +++++++++
 4 files changed

// File: rtl/uio_tx_pkg.sv
// uio_tx_pkg: state encodings, pin-enable constants and default parameters for uio_byte_tx
package uio_tx_pkg;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_STROBE  = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;
  localparam logic [7:0] OE_DRIVE   = 8'hFF;
  localparam logic [7:0] OE_RELEASE = 8'h00;
  localparam int DEF_DEPTH       = 4;
  localparam int DEF_SETUP_CYC   = 2;
  localparam int DEF_TIMEOUT_CYC = 255;
endpackage

// File: rtl/uio_byte_tx_if.sv
// uio_byte_tx_if: byte push handshake plus uio pin/strobe/ack bundle
interface uio_byte_tx_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] data_o;
  logic [7:0] oe_o;
  logic       stb_o;
  logic       ack_i;
  modport master (output in_data, in_valid, ack_i, input in_ready, data_o, oe_o, stb_o);
  modport slave  (input in_data, in_valid, ack_i, output in_ready, data_o, oe_o, stb_o);
endinterface

// File: rtl/uio_byte_fifo.sv
// uio_byte_fifo: power-of-two byte FIFO with head data visible combinationally
module uio_byte_fifo import uio_tx_pkg::*; #(
  parameter int DEPTH = DEF_DEPTH,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      wp    <= wp + AW'(do_push);
      rp    <= rp + AW'(do_pop);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/uio_byte_tx.sv
// uio_byte_tx: FIFO-fed byte sender onto uio pins with strobe/ack handshake; timeout via UIO_TX_TIMEOUT_EN
module uio_byte_tx import uio_tx_pkg::*; #(
  parameter int DEPTH       = DEF_DEPTH,
  parameter int SETUP_CYC   = DEF_SETUP_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic          clk,
  input  logic          rst_n,
  uio_byte_tx_if.slave  bus,
  output logic          busy_o,
  output logic          err_o,
  input  logic          clr_err_i
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(SETUP_CYC + 1);
  state_t state;
  logic [7:0] head, data_q, oe_q;
  logic stb_q, full, empty, ack_m, ack_s, tmo;
  logic [CW-1:0] count;
  logic [SW-1:0] scnt;
  uio_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.in_valid),
    .pop   (state == ST_IDLE),
    .wdata (bus.in_data),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );
  assign bus.in_ready = !full;
  assign bus.data_o   = data_q;
  assign bus.oe_o     = oe_q;
  assign bus.stb_o    = stb_q;
  assign busy_o       = state != ST_IDLE || count != '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {ack_s, ack_m} <= 2'b00;
    else {ack_s, ack_m} <= {ack_m, bus.ack_i};
`ifdef UIO_TX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] wcnt;
  logic err_q;
  assign tmo   = (state == ST_STROBE || state == ST_RELEASE) && wcnt == TW'(TIMEOUT_CYC - 1);
  assign err_o = err_q;
  // wcnt restarts whenever the handshake advances, so each phase gets its own budget
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wcnt  <= '0;
      err_q <= 1'b0;
    end else begin
      wcnt  <= ((state == ST_STROBE && !ack_s) || (state == ST_RELEASE && ack_s)) && !tmo ? wcnt + 1'b1 : '0;
      err_q <= tmo || (err_q && !clr_err_i);
    end
`else
  assign tmo   = 1'b0;
  assign err_o = clr_err_i & TIMEOUT_CYC[0] & 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= ST_IDLE;
      data_q <= 8'h00;
      oe_q   <= OE_RELEASE;
      stb_q  <= 1'b0;
      scnt   <= '0;
    end else begin
      case (state)
        ST_IDLE:
          if (!empty) begin
            state  <= ST_SETUP;
            data_q <= head;
            oe_q   <= OE_DRIVE;
            scnt   <= '0;
          end
        ST_SETUP:
          if (scnt == SW'(SETUP_CYC - 1)) begin
            state <= ST_STROBE;
            stb_q <= 1'b1;
          end else scnt <= scnt + 1'b1;
        ST_STROBE:
          if (ack_s) begin
            state <= ST_RELEASE;
            stb_q <= 1'b0;
          end else if (tmo) begin
            state <= ST_IDLE;
            stb_q <= 1'b0;
            oe_q  <= OE_RELEASE;
          end
        ST_RELEASE:
          if (!ack_s || tmo) begin
            state <= ST_IDLE;
            oe_q  <= OE_RELEASE;
          end
      endcase
    end
endmodule
